// File: rtl/gpr_pkg.sv
// Shared definitions for the multi-port register file: state encoding,
// default geometry and an elaboration-time clog2.
package gpr_pkg;

    localparam logic GPR_S_CLEAR = 1'b0;
    localparam logic GPR_S_RUN   = 1'b1;

    localparam int GPR_WIDTH = 32;
    localparam int GPR_DEPTH = 32;

    function automatic int gpr_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/gpr_rd_port.sv
// One combinational read port: zero-register override, optional same-cycle
// write bypass (highest-numbered port wins), otherwise the array value.
module gpr_rd_port
    import gpr_pkg::*;
#(
    parameter int WIDTH    = GPR_WIDTH,
    parameter int AW       = 5,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                 en,
    input  logic [AW-1:0]        raddr,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic [NWR*WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0]     mem_rd,
    output logic [WIDTH-1:0]     rdata
);

    always_comb begin
        rdata = mem_rd;
        // we already excludes writes dropped by the zero register
        if (BYPASS != 0) begin
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && (waddr[i*AW +: AW] == raddr)) rdata = wdata[i*WIDTH +: WIDTH];
            end
        end
        if (!en || ((ZERO_REG != 0) && (raddr == '0))) rdata = '0;
    end

endmodule

// File: rtl/gpr_mp.sv
// Multi-port general-purpose register file with hardwired zero register,
// optional write bypass and a post-reset sequential clear engine.
module gpr_mp
    import gpr_pkg::*;
#(
    parameter int WIDTH    = GPR_WIDTH,
    parameter int DEPTH    = GPR_DEPTH,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = gpr_clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ready,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic [NWR*WIDTH-1:0] wdata,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             state;
    logic [AW-1:0]    clr_ptr;
    logic [NWR-1:0]   we_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= GPR_S_CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
        end else if (state == GPR_S_CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == AW'(DEPTH - 1)) begin
                state <= GPR_S_RUN;
                ready <= 1'b1;
            end
        end
    end

    always_comb begin
        we_eff = '0;
        for (int i = 0; i < NWR; i++) begin
            we_eff[i] = (state == GPR_S_RUN) && we[i] &&
                        !((ZERO_REG != 0) && (waddr[i*AW +: AW] == '0));
        end
    end

    // Ascending loop order makes the highest-numbered port win a conflict.
    always_ff @(posedge clk) begin
        if (state == GPR_S_CLEAR) begin
            if (!rst) mem[clr_ptr] <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (we_eff[i]) mem[waddr[i*AW +: AW]] <= wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [WIDTH-1:0] mem_rd;

        assign mem_rd = mem[raddr[j*AW +: AW]];

        gpr_rd_port #(
            .WIDTH    (WIDTH),
            .AW       (AW),
            .NWR      (NWR),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .en     (ready),
            .raddr  (raddr[j*AW +: AW]),
            .we     (we_eff),
            .waddr  (waddr),
            .wdata  (wdata),
            .mem_rd (mem_rd),
            .rdata  (rdata[j*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_gpr_mp.sv
// Bench for gpr_mp: one instance with bypass and zero register, one without,
// sharing stimulus and checked against an array-based reference model.
module tb_gpr_mp;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    we;
    logic [2*AW-1:0] waddr;
    logic [2*W-1:0]  wdata;
    logic [2*AW-1:0] raddr;
    logic [2*W-1:0]  rd0, rd1;
    logic          rdy0, rdy1;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m [2][D];
    int           cnt;

    always #5 clk = ~clk;

    gpr_mp #(.WIDTH(W), .DEPTH(D), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut0 (
        .clk(clk), .rst(rst), .ready(rdy0), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr(raddr), .rdata(rd0)
    );

    gpr_mp #(.WIDTH(W), .DEPTH(D), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(0)) dut1 (
        .clk(clk), .rst(rst), .ready(rdy1), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr(raddr), .rdata(rd1)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected read value from the register-file rules; inst 0 has bypass and zero reg.
    function automatic logic [W-1:0] exp_rd(input int inst, input int j);
        int  a;
        bit  zr;
        a  = int'(raddr[j*AW +: AW]);
        zr = (inst == 0);
        if (cnt < D) return '0;
        if (zr && a == 0) return '0;
        if (inst == 0) begin
            for (int i = 1; i >= 0; i--) begin
                if (we[i] && int'(waddr[i*AW +: AW]) == a) return wdata[i*W +: W];
            end
        end
        return m[inst][a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            cnt = 0;
        end else if (cnt < D) begin
            cnt++;
            if (cnt == D) begin
                for (int k = 0; k < 2; k++)
                    for (int r = 0; r < D; r++) m[k][r] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 2; i++) begin
                    if (we[i] && !(k == 0 && waddr[i*AW +: AW] == '0))
                        m[k][int'(waddr[i*AW +: AW])] = wdata[i*W +: W];
                end
            end
        end
    endtask

    task automatic chk_model();
        check("rdy0", {31'b0, rdy0}, {31'b0, cnt >= D});
        check("rdy1", {31'b0, rdy1}, {31'b0, cnt >= D});
        check("d0_rd0", rd0[W-1:0], exp_rd(0, 0));
        check("d0_rd1", rd0[2*W-1:W], exp_rd(0, 1));
        check("d1_rd0", rd1[W-1:0], exp_rd(1, 0));
        check("d1_rd1", rd1[2*W-1:W], exp_rd(1, 1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [1:0] e, input int wa0, input logic [W-1:0] wd0,
                         input int wa1, input logic [W-1:0] wd1, input int ra0, input int ra1);
        we    = e;
        waddr = {AW'(wa1), AW'(wa0)};
        wdata = {wd1, wd0};
        raddr = {AW'(ra1), AW'(ra0)};
    endtask

    task automatic count_clear(input string tag);
        int n;
        n = 0;
        while (!rdy0 && n < 40) begin
            #2 chk_model();
            tick();
            n++;
        end
        check(tag, n, 32);
    endtask

    initial begin
        cnt = 0;
        rst = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // Reset then clear, with an attempted write to addr 5 before ready
        tick(); tick(); tick();
        rst = 1'b0;
        drive(2'b01, 5, 32'hFFFF_FFFF, 0, 0, 5, 1);
        for (int k = 1; k <= 32; k++) begin
            #2 chk_model();
            tick();
            check("rdy_clr", {31'b0, rdy0}, {31'b0, k == 32});
        end
        drive(2'b00, 0, 0, 0, 0, 5, 6);
        #2 check("clr_a5", rd0[W-1:0], 32'h0);
        chk_model();
        tick();

        // Basic write then read
        drive(2'b01, 7, 32'hDEAD_BEEF, 0, 0, 1, 2);
        #2 chk_model();
        tick();
        drive(2'b00, 0, 0, 0, 0, 7, 8);
        #2 check("basic7_d0", rd0[W-1:0], 32'hDEAD_BEEF);
        check("basic7_d1", rd1[W-1:0], 32'hDEAD_BEEF);
        check("basic8", rd0[2*W-1:W], 32'h0);
        chk_model();
        tick();

        // Zero register
        drive(2'b01, 0, 32'h1234_5678, 0, 0, 0, 0);
        #2 check("zr_same_d0", rd0[W-1:0], 32'h0);
        check("zr_same_d1", rd1[W-1:0], 32'h0);
        chk_model();
        tick();
        drive(2'b00, 0, 0, 0, 0, 0, 7);
        #2 check("zr_next_d0", rd0[W-1:0], 32'h0);
        check("zr_next_d1", rd1[W-1:0], 32'h1234_5678);
        chk_model();
        tick();

        // Write conflict
        drive(2'b11, 3, 32'h1111, 3, 32'h2222, 3, 3);
        #2 check("conf_same_d0", rd0[W-1:0], 32'h2222);
        check("conf_same_d1", rd1[W-1:0], 32'h0);
        chk_model();
        tick();
        drive(2'b00, 0, 0, 0, 0, 3, 3);
        #2 check("conf_next_d0", rd0[W-1:0], 32'h2222);
        check("conf_next_d1", rd1[2*W-1:W], 32'h2222);
        chk_model();
        tick();

        // Bypass off versus on
        drive(2'b01, 9, 32'hA5A5_A5A5, 0, 0, 9, 9);
        #2 check("byp_same_d1", rd1[W-1:0], 32'h0);
        check("byp_same_d0", rd0[W-1:0], 32'hA5A5_A5A5);
        chk_model();
        tick();
        drive(2'b00, 0, 0, 0, 0, 9, 9);
        #2 check("byp_next_d1", rd1[W-1:0], 32'hA5A5_A5A5);
        chk_model();
        tick();

        // Reset mid-clear
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        count_clear("clr_len_mid");

        // Reset mid-run after writing addr 4
        drive(2'b01, 4, 32'h55, 0, 0, 4, 4);
        tick();
        drive(2'b00, 0, 0, 0, 0, 4, 4);
        #2 check("a4_written", rd0[W-1:0], 32'h55);
        check("a4_written_d1", rd1[W-1:0], 32'h55);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        count_clear("clr_len_run");
        drive(2'b00, 0, 0, 0, 0, 4, 4);
        #2 check("a4_cleared", rd0[W-1:0], 32'h0);
        check("a4_cleared_d1", rd1[W-1:0], 32'h0);
        tick();

        // Randomised traffic, narrow address range half the time to force conflicts
        for (int c = 0; c < 400; c++) begin
            int hi;
            hi = (c % 2 == 0) ? 7 : 31;
            drive(2'($urandom), $urandom_range(0, hi), $urandom, $urandom_range(0, hi), $urandom,
                  $urandom_range(0, hi), $urandom_range(0, hi));
            rst = (c == 200);
            #2 chk_model();
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
